// File: rtl/store_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | store_buffer : in-order store FIFO that drains to data memory through a   |
// |                req/ack handshake; optional load forwarding when the       |
// |                macro STORE_BUFFER_FWD_EN is defined.                      |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     memwrite,
    input  logic [AW-1:0]            aluout,
    input  logic [DW-1:0]            writedata,
    output logic                     stall,
    output logic                     mem_req,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    input  logic                     mem_ack,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic [AW-1:0]            fwd_addr,
    output logic                     fwd_hit,
    output logic [DW-1:0]            fwd_data
);

    localparam int             PW      = $clog2(DEPTH);
    localparam logic [PW:0]    c_full  = (PW+1)'(DEPTH);
    localparam logic [PW:0]    c_one   = (PW+1)'(1);
    localparam logic [0:0]     c_idle  = 1'b0;
    localparam logic [0:0]     c_issue = 1'b1;

    logic [AW-1:0] r_addr_q [DEPTH];
    logic [DW-1:0] r_data_q [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic          r_overflow;
    logic          r_mem_req;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;

    logic          w_full;
    logic          w_pop;
    logic          w_accept;
    logic          w_drop;
    logic [PW:0]   w_count_nxt;
    logic [PW-1:0] w_nxt_ptr;
    logic [AW-1:0] w_nxt_addr;
    logic [DW-1:0] w_nxt_data;
    logic          w_load_head;
    logic          w_load_next;
    logic          w_clear;

    assign w_full   = (r_count == c_full);
    assign w_pop    = (r_state == c_issue) && mem_ack;
    assign w_accept = memwrite && (!w_full || w_pop);
    assign w_drop   = memwrite && w_full && !w_pop;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_accept, w_pop})
            2'b10:   w_count_nxt = r_count + c_one;
            2'b01:   w_count_nxt = r_count - c_one;
            default: w_count_nxt = r_count;
        endcase
    end

    // When the head being popped is the last stored entry, the store accepted
    // in the same cycle becomes the next head, so take it straight from the core.
    assign w_nxt_ptr = r_rd_ptr + 1'b1;
    always_comb begin
        w_nxt_addr = aluout;
        w_nxt_data = writedata;
        if (r_count > c_one) begin
            w_nxt_addr = r_addr_q[w_nxt_ptr];
            w_nxt_data = r_data_q[w_nxt_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr_q[r_wr_ptr] <= aluout;
            r_data_q[r_wr_ptr] <= writedata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            if (w_drop)   r_overflow <= 1'b1;
        end
    end

    // Drain FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= c_idle;
        else        r_state <= w_state_nxt;
    end

    // Drain FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (r_count != '0) w_state_nxt = c_issue;
            c_issue: if (w_pop && (w_count_nxt == '0)) w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    // Drain FSM: outputs
    always_comb begin
        w_load_head = 1'b0;
        w_load_next = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            c_idle:  w_load_head = (r_count != '0);
            c_issue: begin
                w_load_next = w_pop && (w_count_nxt != '0);
                w_clear     = w_pop && (w_count_nxt == '0);
            end
            default: w_clear = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_load_head) begin
            r_mem_req   <= 1'b1;
            r_mem_addr  <= r_addr_q[r_rd_ptr];
            r_mem_wdata <= r_data_q[r_rd_ptr];
        end else if (w_load_next) begin
            r_mem_req   <= 1'b1;
            r_mem_addr  <= w_nxt_addr;
            r_mem_wdata <= w_nxt_data;
        end else if (w_clear) begin
            r_mem_req   <= 1'b0;
        end
    end

    assign stall     = w_full;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

`ifdef STORE_BUFFER_FWD_EN
    logic [PW-1:0] w_idx;

    // Scan oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        w_idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rd_ptr + PW'(k);
            if (((PW+1)'(k) < r_count) && (r_addr_q[w_idx] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = r_data_q[w_idx];
            end
        end
    end
`else
    logic w_fwd_unused;
    assign w_fwd_unused = ^fwd_addr;
    assign fwd_hit      = 1'b0;
    assign fwd_data     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// Testbench for store_buffer: directed stores with a scoreboard of expected memory writes.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic                   clk       = 1'b0;
    logic                   reset     = 1'b0;
    logic                   memwrite  = 1'b0;
    logic [AW-1:0]          aluout    = '0;
    logic [DW-1:0]          writedata = '0;
    logic                   mem_ack   = 1'b0;
    logic [AW-1:0]          fwd_addr  = '0;
    logic                   stall;
    logic                   mem_req;
    logic [AW-1:0]          mem_addr;
    logic [DW-1:0]          mem_wdata;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic                   fwd_hit;
    logic [DW-1:0]          fwd_data;

    int total = 0;
    int bad   = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] mon_e;

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .aluout(aluout),
        .writedata(writedata), .stall(stall), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .count(count), .overflow(overflow), .fwd_addr(fwd_addr),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted memory write must match the next expected store.
    always @(negedge clk) begin
        if (reset && mem_req && mem_ack) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", 64'(mem_addr), 64'(mon_e[AW+DW-1:DW]));
                check("write_data", 64'(mem_wdata), 64'(mon_e[DW-1:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_write);
        memwrite  = 1'b1;
        aluout    = a;
        writedata = d;
        if (expect_write) exp_q.push_back({a, d});
        tick();
        memwrite = 1'b0;
    endtask

    task automatic ack_cycles(input int n);
        mem_ack = 1'b1;
        repeat (n) tick();
        mem_ack = 1'b0;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int w;
        int d;

        // Reset state
        repeat (2) tick();
        check("rst_count",    64'(count),    64'(0));
        check("rst_mem_req",  64'(mem_req),  64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_stall",    64'(stall),    64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_fwd_hit",  64'(fwd_hit),  64'(0));
        reset = 1'b1;
        tick();

        // Single store, one-cycle latency, single ack
        store(32'd84, 32'd7, 1'b1);
        check("t1_count_after_accept", 64'(count),   64'(1));
        check("t1_req_latency",        64'(mem_req), 64'(0));
        tick();
        check("t1_req",   64'(mem_req),   64'(1));
        check("t1_addr",  64'(mem_addr),  64'(84));
        check("t1_wdata", 64'(mem_wdata), 64'(7));
        ack_cycles(1);
        check("t1_count_drained", 64'(count),   64'(0));
        check("t1_req_dropped",   64'(mem_req), 64'(0));

        // Fill to full with no acks, then overflow
        store(32'd80, 32'h11, 1'b1);
        store(32'd84, 32'h22, 1'b1);
        store(32'd88, 32'h33, 1'b1);
        store(32'd92, 32'h44, 1'b1);
        check("t2_count_full", 64'(count), 64'(4));
        check("t2_stall",      64'(stall), 64'(1));
        store(32'd96, 32'h55, 1'b0);
        check("t2_count_after_drop", 64'(count),    64'(4));
        check("t2_overflow",         64'(overflow), 64'(1));
        check("t2_head_addr",        64'(mem_addr), 64'(80));
        ack_cycles(4);
        check("t2_count_drained", 64'(count),    64'(0));
        check("t2_req_dropped",   64'(mem_req),  64'(0));
        check("t2_overflow_stk",  64'(overflow), 64'(1));
        check("t2_stall_clear",   64'(stall),    64'(0));

        // Full buffer with simultaneous store and ack
        reset_pulse();
        check("t3_overflow_reset", 64'(overflow), 64'(0));
        store(32'd100, 32'hA0, 1'b1);
        store(32'd104, 32'hA4, 1'b1);
        store(32'd108, 32'hA8, 1'b1);
        store(32'd112, 32'hAC, 1'b1);
        check("t3_req",   64'(mem_req),  64'(1));
        check("t3_head",  64'(mem_addr), 64'(100));
        mem_ack = 1'b1;
        store(32'd116, 32'hB0, 1'b1);
        mem_ack = 1'b0;
        check("t3_count_same", 64'(count),    64'(4));
        check("t3_no_overflow", 64'(overflow), 64'(0));
        check("t3_next_head",  64'(mem_addr), 64'(104));
        ack_cycles(4);
        check("t3_count_drained", 64'(count), 64'(0));

        // Asynchronous reset in the middle of a handshake
        store(32'd200, 32'h1, 1'b0);
        tick();
        check("t4_req_before", 64'(mem_req), 64'(1));
        #2 reset = 1'b0;
        #1;
        check("t4_req_async",   64'(mem_req),  64'(0));
        check("t4_count_async", 64'(count),    64'(0));
        check("t4_addr_async",  64'(mem_addr), 64'(0));
        tick();
        reset = 1'b1;
        ack_cycles(3);
        check("t4_req_after",   64'(mem_req), 64'(0));
        check("t4_count_after", 64'(count),   64'(0));

        // Forwarding from the youngest matching entry
        store(32'd80, 32'd5, 1'b1);
        store(32'd80, 32'd9, 1'b1);
        fwd_addr = 32'd80;
        #1;
`ifdef STORE_BUFFER_FWD_EN
        check("t5_fwd_hit",  64'(fwd_hit),  64'(1));
        check("t5_fwd_data", 64'(fwd_data), 64'(9));
        fwd_addr = 32'd84;
        #1;
        check("t5_fwd_miss", 64'(fwd_hit), 64'(0));
`else
        check("t5_fwd_hit_off",  64'(fwd_hit),  64'(0));
        check("t5_fwd_data_off", 64'(fwd_data), 64'(0));
`endif
        ack_cycles(2);
        fwd_addr = 32'd80;
        #1;
        check("t5_count_drained", 64'(count),   64'(0));
        check("t5_fwd_after",     64'(fwd_hit), 64'(0));

        // Acks with random 0..3 cycle delays
        store(32'd300, 32'hC1, 1'b1);
        store(32'd304, 32'hC2, 1'b1);
        store(32'd308, 32'hC3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            w = 0;
            while (!mem_req && w < 10) begin
                tick();
                w++;
            end
            check("t6_wait_req", 64'(mem_req), 64'(1));
            d = int'($urandom_range(0, 3));
            repeat (d) tick();
            ack_cycles(1);
        end
        ack_cycles(4);
        check("t6_queue_empty", 64'(exp_q.size()), 64'(0));
        check("t6_count",       64'(count),        64'(0));
        check("t6_req",         64'(mem_req),      64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of buffered stores (power of two, 2..16).
REQ-002 SHALL have parameter AW, default 32, meaning the store address width.
REQ-003 SHALL have parameter DW, default 32, meaning the store data width.
REQ-004 SHALL have port clk  in  1  meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1  meaning asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port memwrite  in  1  meaning the core's store strobe, one store per high cycle.
REQ-007 SHALL have port aluout  in  AW  meaning the store address from the core.
REQ-008 SHALL have port writedata  in  DW  meaning the store data from the core.
REQ-009 SHALL have port stall  out  1  meaning the buffer is full; the core must hold its store.
REQ-010 SHALL have port mem_req  out  1  meaning a store is presented to data memory.
REQ-011 SHALL have port mem_addr  out  AW  meaning the presented store address.
REQ-012 SHALL have port mem_wdata  out  DW  meaning the presented store data.
REQ-013 SHALL have port mem_ack  in  1  meaning memory accepted the presented store this cycle.
REQ-014 SHALL have port count  out  clog2(DEPTH)+1  meaning the number of occupied entries.
REQ-015 SHALL have port overflow  out  1  meaning a sticky flag for a dropped store.
REQ-016 SHALL have ports fwd_addr in AW, fwd_hit out 1, fwd_data out DW, meaning a load-forwarding lookup.

Function
REQ-017 SHALL be an in-order FIFO; stores reach memory in acceptance order.
REQ-018 SHALL accept a store at a rising edge when memwrite=1 and either count<DEPTH or a pop occurs in the same cycle.
REQ-019 SHALL drive stall combinationally as count==DEPTH.
REQ-020 SHALL drop a store when memwrite=1, the buffer is full and there is no pop; it SHALL set overflow=1 until reset.
REQ-021 SHALL implement a drain FSM with states IDLE and ISSUE.
REQ-022 SHALL, in IDLE with count>0, register the head entry onto mem_addr/mem_wdata, set mem_req=1, and move to ISSUE.
REQ-023 SHALL, in ISSUE, hold mem_req, mem_addr and mem_wdata stable until mem_ack=1 is sampled.
REQ-024 SHALL, on mem_ack in ISSUE, pop the head; if entries remain after the pop, present the next head in the following cycle and stay in ISSUE; otherwise drop mem_req and return to IDLE.
REQ-025 SHALL give a latency of one cycle: a store accepted at edge N into an empty buffer raises mem_req after edge N+1.
REQ-026 SHALL leave count unchanged on a simultaneous accept and pop.
REQ-027 SHALL ignore mem_ack in IDLE.
REQ-028 SHALL wrap its read and write pointers modulo DEPTH.

Reset
REQ-029 SHALL, while reset=0, immediately force count=0, pointers=0, state=IDLE, mem_req=0, mem_addr=0, mem_wdata=0, overflow=0, stall=0 and fwd_hit=0; buffered stores are discarded, including one in mid-handshake.

Configuration
REQ-030 SHALL, with macro STORE_BUFFER_FWD_EN defined, drive fwd_hit=1 combinationally when any occupied entry (including the one in ISSUE) matches fwd_addr, with fwd_data taken from the youngest matching entry.
REQ-031 SHALL, without STORE_BUFFER_FWD_EN, keep the fwd ports present but drive fwd_hit=0 and fwd_data=0.

Verification
REQ-032 SHALL cover: reset, then a store to 84 with data 7 -> mem_req=1 with mem_addr=84 and mem_wdata=7 one cycle later; mem_ack for one cycle -> count=0 and mem_req=0.
REQ-033 SHALL cover: 5 consecutive stores to 80,84,88,92,96 with mem_ack held 0 (DEPTH=4) -> stall=1 after the fourth store, the fifth store dropped, overflow=1.
REQ-034 SHALL cover: a full buffer with memwrite=1 and mem_ack=1 in the same cycle -> the store is accepted, count stays 4, overflow stays 0.
REQ-035 SHALL cover: reset pulled to 0 mid-ISSUE -> mem_req=0 and count=0 without waiting for a clock edge; after release, no memory write occurs.
REQ-036 SHALL cover: stores to 80 with data 5, then 80 with data 9, left pending, fwd_addr=80 -> fwd_hit=1 and fwd_data=9 with FWD_EN, and fwd_hit=0 without it.
REQ-037 SHALL cover: 3 stores acked with random mem_ack delays of 0-3 cycles -> memory sees the same address and data order, with no duplicated writes.
